inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 139 +++++++++++++
 tb/tb_inst_fetch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: single-outstanding-request fetcher feeding a registered fetch/decode
// stage, with a one-entry skid buffer for responses that arrive while decode is stalled.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_addr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   output logic        if_valid_o
);

   typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

   localparam logic [31:0] ResetPcAligned = RESET_PC & 32'hFFFF_FFFC;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        kill_q, kill_d;
   logic [31:0] skid_q, skid_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic        if_valid_q, if_valid_d;
   logic        load;
   logic [31:0] load_data;

   assign imem_req_o  = (state_q == StReq);
   assign imem_addr_o = pc_q;
   assign if_pc_o     = if_pc_q;
   assign if_inst_o   = if_inst_q;
   assign if_valid_o  = if_valid_q;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      kill_d    = kill_q;
      skid_d    = skid_q;
      load      = 1'b0;
      load_data = skid_q;

      if (branch_flag_i) begin
         pc_d   = {branch_addr_i[31:2], 2'b00};
         skid_d = 32'h0;
         unique case (state_q)
            StReq: begin
               // The old address was accepted this cycle; its response must be dropped.
               if (imem_gnt_i) begin
                  state_d = StWait;
                  kill_d  = 1'b1;
               end
            end
            StWait: begin
               if (imem_rvalid_i) begin
                  state_d = StReq;
                  kill_d  = 1'b0;
               end else begin
                  kill_d = 1'b1;
               end
            end
            default: state_d = StReq;
         endcase
      end else begin
         unique case (state_q)
            StReq: begin
               if (imem_gnt_i) state_d = StWait;
            end
            StWait: begin
               if (imem_rvalid_i) begin
                  if (kill_q) begin
                     state_d = StReq;
                     kill_d  = 1'b0;
                  end else if (!stall_i) begin
                     load      = 1'b1;
                     load_data = imem_rdata_i;
                     pc_d      = pc_q + 32'd4;
                     state_d   = StReq;
                  end else begin
                     skid_d  = imem_rdata_i;
                     state_d = StHold;
                  end
               end
            end
            StHold: begin
               if (!stall_i) begin
                  load      = 1'b1;
                  load_data = skid_q;
                  pc_d      = pc_q + 32'd4;
                  state_d   = StReq;
               end
            end
            default: state_d = StReq;
         endcase
      end

      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if_valid_d = if_valid_q;
      if (branch_flag_i) begin
         if_inst_d  = 32'h0;
         if_valid_d = 1'b0;
      end else if (load) begin
         if_pc_d    = pc_q;
         if_inst_d  = load_data;
         if_valid_d = 1'b1;
      end else if (!stall_i) begin
         if_inst_d  = 32'h0;
         if_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StReq;
         pc_q       <= ResetPcAligned;
         kill_q     <= 1'b0;
         skid_q     <= 32'h0;
         if_pc_q    <= 32'h0;
         if_inst_q  <= 32'h0;
         if_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         kill_q     <= kill_d;
         skid_q     <= skid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
         if_valid_q <= if_valid_d;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: memory handshake driven step by step, expected values by hand.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        branch_flag_i = 1'b0;
   logic [31:0] branch_addr_i = 32'h0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        if_valid_o;

   int checks = 0;
   int errors = 0;

   inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .branch_flag_i (branch_flag_i),
      .branch_addr_i (branch_addr_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .if_pc_o       (if_pc_o),
      .if_inst_o     (if_inst_o),
      .if_valid_o    (if_valid_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] inst);
      chk({tag, "_valid"}, {31'h0, if_valid_o}, {31'h0, v});
      chk({tag, "_pc"}, if_pc_o, pc);
      chk({tag, "_inst"}, if_inst_o, inst);
   endtask

   // One unstalled fetch: grant immediately, respond one cycle later.
   task automatic fetch(input logic [31:0] a, input logic [31:0] d);
      chk("fetch_req", {31'h0, imem_req_o}, 32'h1);
      chk("fetch_addr", imem_addr_o, a);
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i = 1'b0;
      chk("wait_req", {31'h0, imem_req_o}, 32'h0);
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = d;
      tick();
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
      chk_out("fetched", 1'b1, a, d);
   endtask

   initial begin
      #1;
      tick();
      tick();
      chk_out("reset", 1'b0, 32'h0, 32'h0);
      rst = 1'b0;
      tick();
      chk("post_rst_req", {31'h0, imem_req_o}, 32'h1);
      chk("post_rst_addr", imem_addr_o, 32'h0);

      // Two back-to-back fetches
      fetch(32'h0, 32'h13);
      imem_gnt_i = 1'b1;
      chk("addr4", imem_addr_o, 32'h4);
      tick();
      imem_gnt_i = 1'b0;
      chk_out("gap", 1'b0, 32'h0, 32'h0);
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'h93;
      tick();
      imem_rvalid_i = 1'b0;
      chk_out("second", 1'b1, 32'h4, 32'h93);

      // Stall while response for address 8 returns
      chk("addr8", imem_addr_o, 32'h8);
      stall_i    = 1'b1;
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_0008;
      tick();
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
      for (int i = 0; i < 3; i++) begin
         chk("hold_req", {31'h0, imem_req_o}, 32'h0);
         chk_out("hold", 1'b1, 32'h4, 32'h93);
         if (i < 2) tick();
      end
      stall_i = 1'b0;
      tick();
      chk_out("unstall", 1'b1, 32'h8, 32'hDEAD_0008);
      chk("addr12", imem_addr_o, 32'hC);
      chk("req12", {31'h0, imem_req_o}, 32'h1);

      // Branch in REQ without grant, then branch while waiting on 0x20
      fetch(32'hC, 32'h0000_000C);
      branch_flag_i = 1'b1;
      branch_addr_i = 32'h20;
      tick();
      branch_flag_i = 1'b0;
      chk("br_req_addr", imem_addr_o, 32'h20);
      chk_out("br_req_flush", 1'b0, 32'hC, 32'h0);
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i    = 1'b0;
      branch_flag_i = 1'b1;
      branch_addr_i = 32'h103;
      tick();
      branch_flag_i = 1'b0;
      chk("kill_wait_req", {31'h0, imem_req_o}, 32'h0);
      chk_out("kill_wait", 1'b0, 32'hC, 32'h0);
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'h0BAD_0020;
      tick();
      imem_rvalid_i = 1'b0;
      chk_out("dropped", 1'b0, 32'hC, 32'h0);
      fetch(32'h100, 32'h55);

      // Branch while stalled still flushes outputs
      stall_i       = 1'b1;
      branch_flag_i = 1'b1;
      branch_addr_i = 32'hFFFF_FFFF;
      tick();
      branch_flag_i = 1'b0;
      stall_i       = 1'b0;
      chk_out("stall_flush", 1'b0, 32'h100, 32'h0);

      // PC wrap
      fetch(32'hFFFF_FFFC, 32'h77);
      chk("wrap_addr", imem_addr_o, 32'h0);

      // Grant withheld for 5 cycles
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("nognt_req", {31'h0, imem_req_o}, 32'h1);
         chk("nognt_addr", imem_addr_o, 32'h0);
         chk("nognt_valid", {31'h0, if_valid_o}, 32'h0);
      end

      // Reset during WAIT with a late response
      fetch(32'h0, 32'h13);
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i = 1'b0;
      rst = 1'b1;
      tick();
      rst           = 1'b0;
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'h0BAD_0004;
      chk_out("mid_rst", 1'b0, 32'h0, 32'h0);
      tick();
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
      chk_out("stale_ignored", 1'b0, 32'h0, 32'h0);
      fetch(32'h0, 32'h13);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
